rr_gray_arbiter: RTL

Sequential round-robin arbiter for eight requesters sharing one resource. It grants one requester at a time and holds the grant until release or a hold-time limit. It reports the grant as a one-hot vector and as a Gray-coded index, using the same highest-index-first priority and Gray index encoding as the team's 8-input priority encoder. It sits in front of any shared datapath (bus, register-file port, encoder input) and tells that datapath which source it serves.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/rr_pick8.sv | 41 ++++
 rtl/rr_gray_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin Gray-index arbiter.
//   state_t   : arbiter FSM states (IDLE, GRANT)
//   NREQ      : number of requesters
//   IDX_W     : width of a requester index
//   bin2gray  : binary index to Gray code, same encoding as the 8-input
//               priority encoder this arbiter pairs with
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int NREQ  = 8;
    localparam int IDX_W = 3;

    function automatic logic [IDX_W-1:0] bin2gray(input logic [IDX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin winner search for eight requesters.
//   req   in  8 : request vector
//   ptr   in  3 : index with the highest priority this round
//   valid out 1 : at least one request is set
//   k     out 3 : winning index; order is ptr, ptr-1, ..., 0, 7, ..., ptr+1
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] k
);

    logic [NREQ-1:0]  rot;
    logic [IDX_W-1:0] pos;

    // Rotate so that req[ptr] lands on bit 7; a plain highest-bit-first
    // search over rot then walks ptr, ptr-1, ... with wrap-around. The index
    // sum is 3 bits wide, so the modulo-8 wrap comes for free.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path leaves it unassigned (no latch).
        rot = '0;
        pos = '0;
        for (int j = 0; j < NREQ; j++) begin
            rot[j] = req[IDX_W'(j) + ptr + 3'd1];
        end
        // Ascending scan: the last set bit seen is the highest one.
        for (int j = 0; j < NREQ; j++) begin
            if (rot[j]) begin
                pos = IDX_W'(j);
            end
        end
    end

    assign valid = |req;
    // Undo the rotation: rotated position pos is requester pos + ptr + 1.
    assign k     = pos + ptr + 3'd1;

endmodule

// File: rtl/rr_gray_arbiter.sv
// Round-robin arbiter for eight requesters sharing one resource.
// A grant is held until done, loss of request, loss of enable, or HOLD_MAX
// cycles, then at least one idle cycle follows so the shared datapath can
// switch sources.
//   HOLD_MAX     : maximum consecutive grant cycles (1..256)
//   clk          : rising-edge clock
//   rst          : asynchronous active-high reset
//   en      in 1 : enable; low releases any grant and blocks new ones
//   req     in 8 : request vector
//   done    in 1 : current holder releases the resource
//   gnt     out 8: registered one-hot grant, 0 when idle
//   idx     out 3: registered Gray code of the granted index, 000 when idle
//   busy    out 1: registered, high while a grant is active
//   act     out 1: combinational en & |req
module rr_gray_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             busy,
    output logic             act
);

    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_k;
    logic             release_now;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .k     (pick_k)
    );

    assign act = en & (|req);

    // Any of these ends the grant; several at once are still one release.
    assign release_now = done | ~req[cur_q] | ~en | (cnt_q == CNT_LAST);

    // Outputs are computed alongside the next state so gnt/idx/busy come
    // straight from flops and change on the same edge as the FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (en && pick_valid) begin
                    state_d = GRANT;
                    cur_d   = pick_k;
                    cnt_d   = '0;
                    // Winner drops to lowest priority next round.
                    ptr_d   = pick_k - 3'd1;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_k;
                    idx_d   = bin2gray(pick_k);
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd7;
            cur_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign idx  = idx_q;
    assign busy = busy_q;

endmodule
